// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from MEM and WB,
// load-use hazard detection (stall plus bubble), downstream hold with
// WB refresh of held operands, branch flush and a saturating counter
// of load-use stall cycles.
module id_ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0] id_reg1,
  input  logic [DATA_W-1:0] id_reg2,
  input  logic              id_is_load,
  input  logic              id_reg_write,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_rs1,
  output logic [ADDR_W-1:0] ex_rs2,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic              ex_is_load,
  output logic              ex_reg_write,
  output logic [7:0]        lu_stall_count
);

  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic              lu;
  logic              refresh1;
  logic              refresh2;

  // Operand select: r0 reads zero, then MEM, then WB, then register file
  always_comb begin
    fwd1 = id_reg1;
    if (id_rs1 == '0)
      fwd1 = '0;
    else if (mem_reg_write && (mem_rd == id_rs1))
      fwd1 = mem_result;
    else if (wb_reg_write && (wb_rd == id_rs1))
      fwd1 = wb_data;

    fwd2 = id_reg2;
    if (id_rs2 == '0)
      fwd2 = '0;
    else if (mem_reg_write && (mem_rd == id_rs2))
      fwd2 = mem_result;
    else if (wb_reg_write && (wb_rd == id_rs2))
      fwd2 = wb_data;
  end

  // Load-use hazard and decode hold; masked in reset so the stale EX
  // contents of the reset cycle cannot raise a stall
  always_comb begin
    lu = !reset && ex_valid && ex_is_load && ex_reg_write && (ex_rd != '0) &&
         id_valid && ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
    id_stall = lu || stall_in;
    refresh1 = ex_valid && wb_reg_write && (wb_rd == ex_rs1) && (ex_rs1 != '0);
    refresh2 = ex_valid && wb_reg_write && (wb_rd == ex_rs2) && (ex_rs2 != '0);
  end

  // ID/EX register: reset > flush > hold > bubble > capture
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_is_load   <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (stall_in) begin
      if (refresh1) ex_op1 <= wb_data;
      if (refresh2) ex_op2 <= wb_data;
    end else if (lu) begin
      ex_valid     <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_op1       <= fwd1;
      ex_op2       <= fwd2;
      ex_is_load   <= id_valid && id_is_load;
      ex_reg_write <= id_valid && id_reg_write;
    end
  end

  // Saturating count of cycles lost to load-use stalls
  always_ff @(posedge clock) begin
    if (reset)
      lu_stall_count <= '0;
    else if (lu && !flush && (lu_stall_count != 8'hFF))
      lu_stall_count <= lu_stall_count + 8'd1;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus a
// randomized run against a behavioural model of the EX slot.
module tb_id_ex_operand_stage;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        stall_in;
  logic        id_valid;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic [15:0] id_reg1, id_reg2;
  logic        id_is_load, id_reg_write;
  logic [3:0]  mem_rd;
  logic        mem_reg_write;
  logic [15:0] mem_result;
  logic [3:0]  wb_rd;
  logic        wb_reg_write;
  logic [15:0] wb_data;
  logic        id_stall;
  logic        ex_valid;
  logic [3:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_op1, ex_op2;
  logic        ex_is_load, ex_reg_write;
  logic [7:0]  lu_stall_count;

  int vectors = 0;
  int errors  = 0;

  id_ex_operand_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush), .stall_in(stall_in),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_is_load(id_is_load),
    .id_reg_write(id_reg_write), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .lu_stall_count(lu_stall_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural model of the EX slot; m_known is clear when the spec
  // leaves the non-control fields unspecified (after flush or bubble).
  logic        m_v, m_ld, m_rw, m_known;
  logic [3:0]  m_rs1, m_rs2, m_rd;
  logic [15:0] m_op1, m_op2;
  int          m_cnt;

  function automatic logic [15:0] ref_operand(input logic [3:0] rs, input logic [15:0] rf);
    logic [3:0]  prod_rd  [2];
    logic        prod_we  [2];
    logic [15:0] prod_val [2];
    prod_rd  = '{mem_rd, wb_rd};
    prod_we  = '{mem_reg_write, wb_reg_write};
    prod_val = '{mem_result, wb_data};
    if (rs == 4'd0) return 16'h0000;
    for (int k = 0; k < 2; k++)
      if (prod_we[k] && prod_rd[k] == rs) return prod_val[k];
    return rf;
  endfunction

  function automatic logic ref_lu();
    return !reset && m_v && m_ld && m_rw && m_rd != 4'd0 && id_valid &&
           (id_rs1 == m_rd || id_rs2 == m_rd);
  endfunction

  task automatic model_edge();
    logic hz;
    hz = ref_lu();
    if (reset) begin
      m_v = 0; m_ld = 0; m_rw = 0; m_known = 1;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op1 = 0; m_op2 = 0; m_cnt = 0;
    end else begin
      if (hz && !flush) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      if (flush) begin
        m_v = 0; m_ld = 0; m_rw = 0; m_known = 0;
      end else if (stall_in) begin
        if (m_v && wb_reg_write && wb_rd == m_rs1 && m_rs1 != 0) m_op1 = wb_data;
        if (m_v && wb_reg_write && wb_rd == m_rs2 && m_rs2 != 0) m_op2 = wb_data;
      end else if (hz) begin
        m_v = 0; m_ld = 0; m_rw = 0; m_known = 0;
      end else begin
        m_known = 1;
        m_v   = id_valid;
        m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
        m_ld  = id_valid & id_is_load;
        m_rw  = id_valid & id_reg_write;
        m_op1 = ref_operand(id_rs1, id_reg1);
        m_op2 = ref_operand(id_rs2, id_reg2);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    reset = 0; flush = 0; stall_in = 0; id_valid = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_reg1 = 0; id_reg2 = 0;
    id_is_load = 0; id_reg_write = 0;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic capture_load_r4();
    drive_idle();
    id_valid = 1; id_is_load = 1; id_reg_write = 1; id_rd = 4'd4;
    id_rs1 = 4'd1; id_rs2 = 4'd2;
    tick();
  endtask

  task automatic test_reset();
    drive_idle();
    id_valid = 1; id_is_load = 1; id_reg_write = 1; id_rd = 4'd9;
    id_rs1 = 4'd9; id_reg1 = 16'hFFFF;
    tick();
    for (int c = 0; c < 2; c++) begin
      reset = 1; stall_in = $urandom_range(0, 1); flush = $urandom_range(0, 1);
      id_valid = 1; id_is_load = 1; id_reg_write = 1;
      id_rs1 = 4'($urandom); id_rs2 = 4'($urandom); id_rd = 4'($urandom);
      id_reg1 = 16'($urandom); id_reg2 = 16'($urandom);
      mem_rd = 4'($urandom); mem_reg_write = 1; mem_result = 16'($urandom);
      wb_rd = 4'($urandom); wb_reg_write = 1; wb_data = 16'($urandom);
      #1;
      vectors++;
      if (id_stall !== stall_in) begin
        errors++; $display("FAIL reset_id_stall: got %b expected %b", id_stall, stall_in);
      end
      tick();
    end
    vectors++;
    if ({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_is_load, ex_reg_write, lu_stall_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rs1=%h rs2=%h rd=%h op1=%h op2=%h ld=%b rw=%b cnt=%0d expected all 0",
               ex_valid, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_is_load, ex_reg_write, lu_stall_count);
    end
    drive_idle();
    id_valid = 1; id_rs1 = 4'd3; id_reg1 = 16'h1234;
    tick();
    vectors++;
    if (ex_op1 !== 16'h1234 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_capture: got op1=%h v=%b expected 1234 1", ex_op1, ex_valid);
    end
  endtask

  task automatic test_forward();
    do_reset();
    id_valid = 1; id_rs1 = 4'd5; id_reg1 = 16'h0001;
    mem_rd = 4'd5; mem_result = 16'h00AA; mem_reg_write = 1;
    wb_rd = 4'd5; wb_data = 16'hBBBB; wb_reg_write = 1;
    tick();
    vectors++;
    if (ex_op1 !== 16'h00AA) begin
      errors++; $display("FAIL fwd_mem_priority: got %h expected 00aa", ex_op1);
    end
    mem_reg_write = 0;
    tick();
    vectors++;
    if (ex_op1 !== 16'hBBBB) begin
      errors++; $display("FAIL fwd_wb: got %h expected bbbb", ex_op1);
    end
    id_rs1 = 4'd0; mem_rd = 4'd0; mem_reg_write = 1; wb_rd = 4'd0;
    tick();
    vectors++;
    if (ex_op1 !== 16'h0000) begin
      errors++; $display("FAIL fwd_r0: got %h expected 0000", ex_op1);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    capture_load_r4();
    id_valid = 1; id_is_load = 0; id_rs1 = 4'd1; id_rs2 = 4'd4; id_rd = 4'd6;
    id_reg2 = 16'hDEAD;
    #1;
    vectors++;
    if (id_stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall_raised: got %b expected 1", id_stall);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || lu_stall_count !== 8'd1 || id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble: got v=%b cnt=%0d stall=%b expected 0 1 0", ex_valid, lu_stall_count, id_stall);
    end
    mem_rd = 4'd4; mem_reg_write = 1; mem_result = 16'h5A5A;
    tick();
    vectors++;
    if (ex_op2 !== 16'h5A5A || ex_valid !== 1'b1 || ex_rd !== 4'd6) begin
      errors++; $display("FAIL lu_mem_forward: got op2=%h v=%b rd=%h expected 5a5a 1 6", ex_op2, ex_valid, ex_rd);
    end
  endtask

  task automatic test_hold_refresh();
    do_reset();
    id_valid = 1; id_rs1 = 4'd7; id_rs2 = 4'd2; id_rd = 4'd3; id_reg_write = 1;
    id_reg1 = 16'h1111; id_reg2 = 16'h2222;
    tick();
    stall_in = 1;
    id_rs1 = 4'd9; id_rs2 = 4'd10; id_rd = 4'd11; id_reg1 = 16'hAAAA; id_reg2 = 16'hBBBB;
    for (int c = 1; c <= 3; c++) begin
      wb_rd = 4'd7; wb_reg_write = (c == 2); wb_data = 16'hC0DE;
      mem_rd = 4'd7; mem_reg_write = (c == 3); mem_result = 16'hFFFF;
      #1;
      vectors++;
      if (id_stall !== 1'b1) begin
        errors++; $display("FAIL hold_id_stall c%0d: got %b expected 1", c, id_stall);
      end
      tick();
      vectors++;
      if (ex_op1 !== ((c == 1) ? 16'h1111 : 16'hC0DE) || ex_op2 !== 16'h2222 ||
          ex_rs1 !== 4'd7 || ex_rs2 !== 4'd2 || ex_rd !== 4'd3 ||
          ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_is_load !== 1'b0) begin
        errors++;
        $display("FAIL hold_refresh c%0d: got op1=%h op2=%h rs1=%h rs2=%h rd=%h v=%b rw=%b ld=%b expected %h 2222 7 2 3 1 1 0",
                 c, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd, ex_valid, ex_reg_write, ex_is_load,
                 (c == 1) ? 16'h1111 : 16'hC0DE);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    capture_load_r4();
    id_valid = 1; id_rs1 = 4'd4; stall_in = 1; flush = 1;
    #1;
    vectors++;
    if (id_stall !== 1'b1) begin
      errors++; $display("FAIL flush_id_stall: got %b expected 1", id_stall);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_is_load !== 1'b0 || lu_stall_count !== 8'd0) begin
      errors++;
      $display("FAIL flush_priority: got v=%b rw=%b ld=%b cnt=%0d expected 0 0 0 0",
               ex_valid, ex_reg_write, ex_is_load, lu_stall_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    capture_load_r4();
    id_valid = 1; id_rs1 = 4'd4; stall_in = 1;
    for (int c = 1; c <= 260; c++) begin
      tick();
      if (c == 100 || c == 254) begin
        vectors++;
        if (lu_stall_count !== 8'(c)) begin
          errors++; $display("FAIL sat_count_%0d: got %0d expected %0d", c, lu_stall_count, c);
        end
      end
    end
    vectors++;
    if (lu_stall_count !== 8'd255) begin
      errors++; $display("FAIL sat_limit: got %0d expected 255", lu_stall_count);
    end
  endtask

  task automatic test_random();
    logic exp_stall;
    drive_idle();
    reset = 1;
    model_edge();
    tick();
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 79) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      stall_in      = ($urandom_range(0, 4) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs1        = 4'($urandom_range(0, 5));
      id_rs2        = 4'($urandom_range(0, 5));
      id_rd         = 4'($urandom_range(0, 5));
      id_reg1       = 16'($urandom);
      id_reg2       = 16'($urandom);
      id_is_load    = ($urandom_range(0, 2) == 0);
      id_reg_write  = ($urandom_range(0, 3) != 0);
      mem_rd        = 4'($urandom_range(0, 5));
      mem_reg_write = $urandom_range(0, 1);
      mem_result    = 16'($urandom);
      wb_rd         = 4'($urandom_range(0, 5));
      wb_reg_write  = $urandom_range(0, 1);
      wb_data       = 16'($urandom);
      exp_stall = ref_lu() || stall_in;
      #1;
      vectors++;
      if (id_stall !== exp_stall) begin
        errors++; $display("FAIL rand_id_stall @%0d: got %b expected %b", i, id_stall, exp_stall);
      end
      model_edge();
      tick();
      vectors++;
      if (ex_valid !== m_v || ex_is_load !== m_ld || ex_reg_write !== m_rw || lu_stall_count !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL rand_ctrl @%0d: got v=%b ld=%b rw=%b cnt=%0d expected %b %b %b %0d",
                 i, ex_valid, ex_is_load, ex_reg_write, lu_stall_count, m_v, m_ld, m_rw, m_cnt);
      end
      if (m_known) begin
        vectors++;
        if (ex_rs1 !== m_rs1 || ex_rs2 !== m_rs2 || ex_rd !== m_rd || ex_op1 !== m_op1 || ex_op2 !== m_op2) begin
          errors++;
          $display("FAIL rand_fields @%0d: got rs1=%h rs2=%h rd=%h op1=%h op2=%h expected %h %h %h %h %h",
                   i, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, m_rs1, m_rs2, m_rd, m_op1, m_op2);
        end
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_forward();
    test_load_use();
    test_hold_refresh();
    test_flush();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
